// File: rtl/prbs_share_ctrl_pkg.sv
// Shared definitions for the shared PRBS controller: FSM states, LFSR geometry
// and the single-step LFSR function.
package prbs_pkg;

  localparam int unsigned LFSR_W = 7;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned TAP_HI = 6;
  localparam int unsigned TAP_LO = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_e;

  // Fibonacci step for x^7 + x^6 + 1: shift left, feed back tap6 ^ tap5.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr7_core.sv
// 7-bit LFSR state holder with seed load, zero-seed substitution and an
// inverted-XOR parity output.
module lfsr7_core
  import prbs_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_SEED = 7'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state,
  output logic              parity
);

  if (RESET_SEED == '0) begin : g_bad_seed
    $error("lfsr7_core: RESET_SEED must be non-zero");
  end

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // An all-zero seed would lock the register up, so it is replaced by RESET_SEED.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_val == '0) ? RESET_SEED : load_val;
    end else if (en) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state  = state_q;
  assign parity = ~^state_q;

endmodule

// File: rtl/prbs_share_ctrl.sv
// Shares one 7-bit LFSR between two requesters: round-robin grant, STEPS
// advances per grant, then one {parity, lfsr} response word.
module prbs_share_ctrl
  import prbs_pkg::*;
#(
  parameter int unsigned       STEPS      = 7,
  parameter logic [LFSR_W-1:0] RESET_SEED = 7'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [WORD_W-1:0] rsp_data,
  output logic              busy
);

  if (STEPS < 1 || STEPS > 15) begin : g_bad_steps
    $error("prbs_share_ctrl: STEPS must be in 1..15");
  end

  localparam logic [3:0] STEPS_C = 4'(STEPS);

  state_e            state_q;
  logic              rr_q;
  logic              id_q;
  logic [3:0]        cnt_q;
  logic [1:0]        gnt_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [WORD_W-1:0] rsp_data_q;

  logic              win;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_par;

  lfsr7_core #(
    .RESET_SEED(RESET_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == RUN),
    .load    ((state_q == IDLE) && seed_load),
    .load_val(seed_val),
    .state   (lfsr),
    .parity  (lfsr_par)
  );

  always_comb begin
    win = req[rr_q] ? rr_q : ~rr_q;
  end

  // seed_load has priority in IDLE: the request stays pending for a later cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!seed_load && (req != 2'b00)) begin
            gnt_q   <= win ? 2'b10 : 2'b01;
            id_q    <= win;
            cnt_q   <= STEPS_C;
            state_q <= RUN;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          rsp_data_q  <= {lfsr_par, lfsr};
          rr_q        <= ~id_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_prbs_share_ctrl.sv
// Directed bench for prbs_share_ctrl with STEPS=7 and hand-computed LFSR words.
module tb_prbs_share_ctrl;

  logic       clk;
  logic       rst;
  logic       seed_load;
  logic [6:0] seed_val;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       busy;

  int n_tests;
  int n_fail;

  prbs_share_ctrl #(
    .STEPS     (7),
    .RESET_SEED(7'h01)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .seed_load(seed_load),
    .seed_val (seed_val),
    .req      (req),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a grant, then for the response; checks wait, latency,
  // id, data and that no grant overlaps the response window.
  task automatic txn(input string tag, input logic [1:0] eg, input logic [7:0] ed,
                     input int exp_wait, input bit drop, input bit pulse_seed);
    int n;
    int m;
    int ov;
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == 2'b00 && n < 30);
    check({tag, "_gnt_wait"}, 32'(n), 32'(exp_wait));
    check({tag, "_gnt"}, 32'(gnt), 32'(eg));
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    if (drop) req = 2'b00;
    m  = 0;
    ov = 0;
    do begin
      if (pulse_seed) begin
        seed_load = (m == 2);
        seed_val  = 7'h40;
      end
      tick();
      m++;
      if (gnt != 2'b00) ov++;
    end while (!rsp_valid && m < 30);
    seed_load = 1'b0;
    check({tag, "_latency"}, 32'(m), 32'd8);
    check({tag, "_no_gnt_overlap"}, 32'(ov), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'(eg[1]));
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'(ed));
    check({tag, "_busy_resp"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    int seen;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    seed_load = 1'b0;
    seed_val  = 7'h00;
    req       = 2'b00;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Single requester 0: 0x01 -> 0x03 after 7 steps.
    req = 2'b01;
    txn("t1", 2'b01, 8'h83, 1, 1'b1, 1'b0);
    tick();
    check("t1_valid_pulse", 32'(rsp_valid), 32'd0);
    check("t1_data_hold", 32'(rsp_data), 32'h83);

    // Both requesting: pointer now at 1, so grants go 1,0,1 back to back.
    req = 2'b11;
    txn("t2a", 2'b10, 8'h85, 1, 1'b0, 1'b0);
    txn("t2b", 2'b01, 8'h8F, 1, 1'b0, 1'b0);
    txn("t2c", 2'b10, 8'h91, 1, 1'b1, 1'b0);
    tick();

    // Seed load beats a same-cycle request; 0x40 -> 0x41.
    seed_load = 1'b1;
    seed_val  = 7'h40;
    req       = 2'b10;
    tick();
    check("t3_no_gnt_on_seed", 32'(gnt), 32'd0);
    check("t3_idle_on_seed", 32'(busy), 32'd0);
    seed_load = 1'b0;
    txn("t3", 2'b10, 8'hC1, 1, 1'b1, 1'b0);
    tick();

    // Zero seed replaced by 0x01.
    seed_load = 1'b1;
    seed_val  = 7'h00;
    tick();
    seed_load = 1'b0;
    req       = 2'b01;
    txn("t4", 2'b01, 8'h83, 1, 1'b1, 1'b0);
    tick();

    // Reset three cycles into RUN aborts the transaction.
    req = 2'b01;
    k = 0;
    do begin
      tick();
      k++;
    end while (gnt == 2'b00 && k < 30);
    check("t5_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_gnt", 32'(gnt), 32'd0);
    check("t5_rst_valid", 32'(rsp_valid), 32'd0);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("t5_no_rsp_after_abort", 32'(seen), 32'd0);
    check("t5_data_cleared", 32'(rsp_data), 32'h00);
    req = 2'b01;
    txn("t5", 2'b01, 8'h83, 1, 1'b1, 1'b0);
    tick();

    // Seed pulse during RUN is dropped; 0x03 -> 0x05 as usual.
    req = 2'b10;
    txn("t6", 2'b10, 8'h85, 1, 1'b1, 1'b1);
    tick();
    check("t6_idle_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
